serial_to_parallel: RTL and testbench

SERIAL_TO_PARALLEL -- requirements
Module: serial_to_parallel

---
 rtl/serial_to_parallel_pkg.sv | 22 ++
 rtl/serial_to_parallel_if.sv | 48 ++++
 rtl/serial_to_parallel.sv | 126 ++++++++++++
 tb/tb_serial_to_parallel.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_to_parallel_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : serial_to_parallel_pkg                                 |
// | Description : Constants and types shared by the serial-to-parallel   |
// |               collector and the parallel-to-serial transmitter:      |
// |               default word width, default features per frame, the    |
// |               collector state encoding and the frame counter width.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package serial_to_parallel_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_N_FEAT = 5;
  localparam int FRAME_CNT_W    = 16;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

endpackage : serial_to_parallel_pkg
`default_nettype wire

// File: rtl/serial_to_parallel_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface   : serial_to_parallel_if                                  |
// | Description : Serial input stream plus parallel frame output of the  |
// |               collector, with its status flags.                      |
// |   in_valid  : serial word present on serial_i                        |
// |   sof       : word is a frame header (qualified by in_valid)         |
// |   serial_i  : serial data word, WIDTH bits                           |
// |   out_ready : consumer accepts the held frame                        |
// |   out_valid : a complete frame is held on feat_o                     |
// |   feat_o    : frame, feature k at [k*WIDTH +: WIDTH]                 |
// |   busy      : a frame is being collected                             |
// |   frame_err : pulse, frame aborted by an early sof                   |
// |   overflow  : pulse, completed frame dropped, output full            |
// |   frame_cnt : number of frames handed over, wrapping                 |
// | Modports    : master = stream source / frame sink, slave = collector |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface serial_to_parallel_if
  import serial_to_parallel_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int N_FEAT = DEFAULT_N_FEAT
);

  logic                      in_valid;
  logic                      sof;
  logic [WIDTH-1:0]          serial_i;
  logic                      out_ready;
  logic                      out_valid;
  logic [N_FEAT*WIDTH-1:0]   feat_o;
  logic                      busy;
  logic                      frame_err;
  logic                      overflow;
  logic [FRAME_CNT_W-1:0]    frame_cnt;

  modport master (
    output in_valid, sof, serial_i, out_ready,
    input  out_valid, feat_o, busy, frame_err, overflow, frame_cnt
  );

  modport slave (
    input  in_valid, sof, serial_i, out_ready,
    output out_valid, feat_o, busy, frame_err, overflow, frame_cnt
  );

endinterface : serial_to_parallel_if
`default_nettype wire

// File: rtl/serial_to_parallel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : serial_to_parallel                                     |
// | Description : Collects a header word followed by N_FEAT feature      |
// |               words into a frame and presents it in parallel with a  |
// |               valid/ready handshake. The collect buffer and the      |
// |               output register are separate, so the next frame can   |
// |               be gathered while the previous one waits for the       |
// |               consumer.                                              |
// | Ports       : clk  - clock, rising edge                              |
// |               rst  - asynchronous reset, active low                  |
// |               bus  - serial_to_parallel_if.slave (stream in, frame   |
// |                      out, busy/frame_err/overflow/frame_cnt)         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module serial_to_parallel
  import serial_to_parallel_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int N_FEAT = DEFAULT_N_FEAT
) (
  input  wire logic              clk,
  input  wire logic              rst,
  serial_to_parallel_if.slave    bus
);

  localparam int IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(N_FEAT - 1);

  state_t                         r_state;
  logic [IDX_W-1:0]               r_idx;
  logic [N_FEAT-1:0][WIDTH-1:0]   r_buf;
  logic [N_FEAT-1:0][WIDTH-1:0]   r_feat;
  logic                           r_out_valid;
  logic                           r_frame_err;
  logic                           r_overflow;
  logic [FRAME_CNT_W-1:0]         r_frame_cnt;

  logic                           w_accept;
  logic                           w_last;
  logic [N_FEAT-1:0][WIDTH-1:0]   w_frame;

  assign w_accept = r_out_valid && bus.out_ready;
  assign w_last   = (r_idx == C_LAST_IDX);

  // The final word is still on serial_i when the frame completes, so the
  // frame to load is the buffer with the current slot taken from the input.
  always_comb begin
    w_frame = r_buf;
    for (int k = 0; k < N_FEAT; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_frame[k] = bus.serial_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_buf       <= '0;
      r_feat      <= '0;
      r_out_valid <= 1'b0;
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;

      if (w_accept) begin
        r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
        r_out_valid <= 1'b0;
      end

      if (bus.in_valid) begin
        case (r_state)
          ST_IDLE: begin
            // Header slot carries no feature data; stray words are ignored.
            if (bus.sof) begin
              r_idx   <= '0;
              r_state <= ST_COLLECT;
            end
          end

          ST_COLLECT: begin
            if (bus.sof) begin
              // Early header: drop the partial frame and restart on this one.
              r_frame_err <= 1'b1;
              r_idx       <= '0;
            end else begin
              r_buf[r_idx] <= bus.serial_i;
              if (w_last) begin
                r_idx   <= '0;
                r_state <= ST_IDLE;
                // Output slot is free now or is being emptied this very cycle.
                if (!r_out_valid || w_accept) begin
                  r_feat      <= w_frame;
                  r_out_valid <= 1'b1;
                end else begin
                  r_overflow  <= 1'b1;
                end
              end else begin
                r_idx <= r_idx + IDX_W'(1);
              end
            end
          end

          default: begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.feat_o    = r_feat;
  assign bus.busy      = (r_state == ST_COLLECT);
  assign bus.frame_err = r_frame_err;
  assign bus.overflow  = r_overflow;
  assign bus.frame_cnt = r_frame_cnt;

endmodule : serial_to_parallel
`default_nettype wire

// File: tb/tb_serial_to_parallel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_serial_to_parallel                                  |
// | Description : Directed scoreboard bench for serial_to_parallel.      |
// |               Stimulus pushes the expected frame into a queue; a     |
// |               monitor pops and compares on every handshake and       |
// |               counts frame_err / overflow pulses.                    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_serial_to_parallel;
  import serial_to_parallel_pkg::*;

  localparam int W  = 32;
  localparam int NF = 5;
  localparam int FW = W * NF;

  logic clk;
  logic rst;

  serial_to_parallel_if #(.WIDTH(W), .N_FEAT(NF)) bus ();

  serial_to_parallel #(.WIDTH(W), .N_FEAT(NF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_err  = 0;
  int n_ovf  = 0;
  logic [FW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Frame whose feature k is base+k+1.
  function automatic logic [FW-1:0] mkf(input logic [W-1:0] base);
    logic [FW-1:0] f;
    f = '0;
    for (int k = 0; k < NF; k++) f[k*W +: W] = base + W'(k + 1);
    return f;
  endfunction

  // Monitor: compares every delivered frame and counts status pulses.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.frame_err) n_err++;
      if (bus.overflow)  n_ovf++;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", bus.feat_o, '0);
          if (bus.feat_o === '0) begin
            errors++;
            $display("FAIL unexpected_frame: got frame with empty queue, expected none");
          end
        end else begin
          chk("frame_data", bus.feat_o, exp_q.pop_front());
        end
      end
    end
  end

  task automatic send(input logic s, input logic [W-1:0] d);
    bus.in_valid = 1'b1;
    bus.sof      = s;
    bus.serial_i = d;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.sof      = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [W-1:0] base, input bit push, input int gap);
    if (push) exp_q.push_back(mkf(base));
    send(1'b1, 32'hDEAD0000);
    for (int k = 0; k < NF; k++) begin
      if (gap > 0) idle(gap);
      send(1'b0, base + W'(k + 1));
    end
  endtask

  initial begin
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.sof       = 1'b0;
    bus.serial_i  = '0;
    bus.out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_out_valid", FW'(bus.out_valid), '0);
    chk("rst_busy",      FW'(bus.busy), '0);
    chk("rst_feat",      bus.feat_o, '0);
    chk("rst_cnt",       FW'(bus.frame_cnt), '0);
    chk("rst_pulses",    FW'({bus.frame_err, bus.overflow}), '0);
    #10 rst = 1'b1;
    idle(1);

    // Test 1: back-to-back frame 1..5
    send_frame(32'h0, 1'b1, 0);
    chk("t1_out_valid", FW'(bus.out_valid), FW'(1));
    chk("t1_feat", bus.feat_o, mkf(32'h0));
    idle(1);
    chk("t1_cnt", FW'(bus.frame_cnt), FW'(1));
    chk("t1_valid_fall", FW'(bus.out_valid), '0);

    // Test 2: same frame with 2-cycle gaps, busy tracking
    exp_q.push_back(mkf(32'h0));
    send(1'b1, 32'hDEAD0000);
    chk("t2_busy_hdr", FW'(bus.busy), FW'(1));
    for (int k = 0; k < NF - 1; k++) begin
      idle(2);
      send(1'b0, 32'(k + 1));
    end
    idle(2);
    chk("t2_busy_pre_last", FW'(bus.busy), FW'(1));
    send(1'b0, 32'd5);
    chk("t2_busy_done", FW'(bus.busy), '0);
    chk("t2_feat", bus.feat_o, mkf(32'h0));
    idle(1);
    chk("t2_cnt", FW'(bus.frame_cnt), FW'(2));

    // Test 3: early sof aborts partial frame
    send(1'b1, 32'hDEAD0000);
    send(1'b0, 32'h11);
    send(1'b0, 32'h22);
    send_frame(32'h9, 1'b1, 0);
    chk("t3_feat", bus.feat_o, mkf(32'h9));
    idle(1);
    chk("t3_cnt", FW'(bus.frame_cnt), FW'(3));

    // Test 4: output held, second frame overflows
    bus.out_ready = 1'b0;
    send_frame(32'h100, 1'b1, 0);
    chk("t4_first_valid", FW'(bus.out_valid), FW'(1));
    send_frame(32'h200, 1'b0, 0);
    chk("t4_overflow", FW'(bus.overflow), FW'(1));
    chk("t4_held", bus.feat_o, mkf(32'h100));
    bus.out_ready = 1'b1;
    idle(1);
    chk("t4_ovf_one_cycle", FW'(bus.overflow), '0);
    chk("t4_cnt", FW'(bus.frame_cnt), FW'(4));
    chk("t4_valid_fall", FW'(bus.out_valid), '0);

    // Test 5: asynchronous reset mid-frame
    send(1'b1, 32'hDEAD0000);
    send(1'b0, 32'h301);
    send(1'b0, 32'h302);
    send(1'b0, 32'h303);
    #2 rst = 1'b0;
    #1;
    chk("t5_async_busy", FW'(bus.busy), '0);
    chk("t5_async_cnt",  FW'(bus.frame_cnt), '0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    idle(1);
    for (int k = 0; k < 7; k++) send(1'b0, 32'h400 + 32'(k));
    chk("t5_ignored_busy",  FW'(bus.busy), '0);
    chk("t5_ignored_valid", FW'(bus.out_valid), '0);
    send_frame(32'h500, 1'b1, 0);
    chk("t5_feat", bus.feat_o, mkf(32'h500));
    idle(1);
    chk("t5_cnt", FW'(bus.frame_cnt), FW'(1));

    // Test 6: new frame completes in the accepting cycle
    bus.out_ready = 1'b0;
    send_frame(32'h600, 1'b1, 0);
    exp_q.push_back(mkf(32'h700));
    send(1'b1, 32'hDEAD0000);
    for (int k = 0; k < NF - 1; k++) send(1'b0, 32'h700 + 32'(k + 1));
    bus.out_ready = 1'b1;
    send(1'b0, 32'h700 + 32'(NF));
    chk("t6_no_overflow", FW'(bus.overflow), '0);
    chk("t6_valid", FW'(bus.out_valid), FW'(1));
    chk("t6_feat", bus.feat_o, mkf(32'h700));
    chk("t6_cnt", FW'(bus.frame_cnt), FW'(2));
    idle(1);
    chk("t6_cnt2", FW'(bus.frame_cnt), FW'(3));
    chk("t6_valid_fall", FW'(bus.out_valid), '0);

    // Final bookkeeping
    idle(3);
    chk("queue_empty", FW'(exp_q.size()), '0);
    chk("frame_err_total", FW'(n_err), FW'(1));
    chk("overflow_total", FW'(n_ovf), FW'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_serial_to_parallel
`default_nettype wire
